vram_port_arbiter: RTL
======================

# vram_port_arbiter

Shares the tile-map memory's second port (addr2 / dataOut2 of the external memory) between the VGA glyph fetch and a queue of game-side tile writes. During visible pixels it issues tile-map read addresses and presents the fetched glyph code to the bit generator. During blanking it drains queued glyph writes into the tile map. It sits between the VGA timing block, the bit generator and the game engine's trail/bike renderer.

## Interface
- FIFO_DEPTH, 4: write-request queue entries; power of two, 2..16.
- BASE_ADDR, 16'd40000: word address of tile (0,0).
- COLS, 160: tiles per row (640/4).
- ROWS, 120: tile rows (480/4).

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bright  in  1  visible-pixel flag from VGA timing.
- hCount  in  16  current pixel column.
- vCount  in  16  current pixel row.
- wr_req  in  1  push one tile write.
- wr_x  in  8  tile column.
- wr_y  in  7  tile row.
- wr_glyph  in  16  glyph code to store.
- wr_ready  out  1  queue can accept a push this cycle.
- mem_addr  out  16  memory port-2 address.
- mem_we  out  1  memory port-2 write enable.
- mem_wdata  out  16  memory port-2 write data.
- mem_rdata  in  16  memory port-2 read data; synchronous, valid 1 cycle after mem_addr.
- glyph  out  16  fetched glyph code to the bit generator.
- glyph_valid  out  1  glyph corresponds to a visible-pixel fetch.
- overflow  out  1  sticky: a push was dropped.
- bad_coord  out  1  sticky: a queued write had wr_x ≥ COLS or wr_y ≥ ROWS.
- clear_busy  out  1  power-up clear in progress.

## Operation
- States: CLEAR, DISPLAY, BLANK. Reset enters CLEAR if the macro is defined, otherwise BLANK.
- DISPLAY (bright=1):
  - mem_addr ← BASE_ADDR + (vCount>>2)·COLS + (hCount>>2), registered; mem_we ← 0.
  - The queue holds.
- BLANK (bright=0):
  - If the queue is non-empty, pop one entry per cycle.
  - Drive mem_addr ← BASE_ADDR + wr_y·COLS + wr_x, mem_wdata ← wr_glyph, mem_we ← 1, all registered.
  - If the queue is empty, mem_we ← 0 and mem_addr holds its value.
- Transitions:
  - DISPLAY→BLANK on the first cycle bright=0.
  - BLANK→DISPLAY on the first cycle bright=1; a write popped in that cycle is not issued and stays queued.
- Coordinate check at pop: out-of-range entries are discarded without a write and set bad_coord.
- Address arithmetic uses 16-bit unsigned math and wraps modulo 2^16.
- Queue:
  - wr_ready = !full && state≠CLEAR, computed from the registered level.
  - A push while wr_ready=0 is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-empty queue leaves the level unchanged.
  - Entries are written in push order.
- glyph ← mem_rdata, registered. glyph_valid is bright delayed 2 cycles. glyph is forced to 0 while glyph_valid=0.
- overflow and bad_coord clear only on reset.

## Timing
- Reset values:
  - mem_addr=BASE_ADDR; mem_we=0; mem_wdata=0.
  - glyph=0; glyph_valid=0; wr_ready=0.
  - overflow=0; bad_coord=0; queue empty.
  - clear_busy=1 with the macro, 0 without.
- Display latency: hCount/vCount sampled at edge N → mem_addr at N+1 → mem_rdata at N+2 → glyph at edge N+2, visible in cycle N+2. The bit generator pipelines its pixel counters by 2.
- Write latency: pop at edge N → mem_we high in cycle N+1. Maximum drain rate is one write per cycle.
- Reset asserted mid-drain flushes the queue. A write in flight may be truncated.

## Configuration
- CLEAR_ON_RESET_EN defined:
  - After reset release, CLEAR writes 16'd0 to BASE_ADDR … BASE_ADDR+COLS·ROWS−1, one word per cycle, ignoring bright. That is 19200 cycles for the defaults.
  - During CLEAR: clear_busy=1, wr_ready=0, glyph_valid=0.
  - On completion, go to BLANK if bright=0, or DISPLAY if bright=1.
- CLEAR_ON_RESET_EN undefined: no CLEAR state exists and clear_busy is tied to 0.

## Test plan
- Display fetch: bright=1, hCount=8, vCount=4 → mem_addr=40162 next cycle, mem_we=0. mem_rdata=16'd4 → glyph=4 and glyph_valid=1 two cycles after sampling.
- Blank drain: bright=0, push (0,0,1), (159,119,2), (5,3,34) → mem_we high for 3 consecutive cycles. Addresses 40000, 59199, 40485; data 1, 2, 34.
- Deferral: push 2 writes with bright=1 → no mem_we. bright falls → both written back-to-back starting 2 cycles later. bright rises mid-drain → remaining entry is kept and written in the next blank.
- Overflow: bright=1, push 5 entries with FIFO_DEPTH=4 → wr_ready=0 after the 4th, 5th dropped, overflow=1. All 4 accepted entries are written in order in the next blank.
- Bad coordinate: push (160,0,1) then (0,120,1) in blank → no mem_we for either, bad_coord=1.
- Clear (macro on): release reset → clear_busy=1 for 19200 cycles, mem_we=1, addresses 40000…59199, mem_wdata=0. Then clear_busy=0 and wr_ready=1. Reasserting rst_n low mid-clear restarts the clear at 40000.

Source files
------------

// File: rtl/vram_port_arbiter_if.sv
// Port-2 bundle for vram_port_arbiter: VGA timing inputs, game-side write queue,
// the tile-map memory port and status flags. The arbiter connects through the slave modport.
interface vram_port_arbiter_if;
    logic        bright;
    logic [15:0] hCount;
    logic [15:0] vCount;
    logic        wr_req;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [15:0] wr_glyph;
    logic        wr_ready;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] glyph;
    logic        glyph_valid;
    logic        overflow;
    logic        bad_coord;
    logic        clear_busy;

    modport master (
        output bright, hCount, vCount, wr_req, wr_x, wr_y, wr_glyph, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata, glyph, glyph_valid,
               overflow, bad_coord, clear_busy
    );

    modport slave (
        input  bright, hCount, vCount, wr_req, wr_x, wr_y, wr_glyph, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata, glyph, glyph_valid,
               overflow, bad_coord, clear_busy
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares tile-map port 2 between visible-pixel glyph fetches and queued game writes
// drained during blanking. Define CLEAR_ON_RESET_EN to zero the tile map after reset.
module vram_port_arbiter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASE_ADDR  = 16'd40000,
    parameter int          COLS       = 160,
    parameter int          ROWS       = 120
) (
    input logic               clk,
    input logic               rst_n,
    vram_port_arbiter_if.slave bus
);
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] COLS16  = 16'(COLS);
    localparam logic [15:0] ROWS16  = 16'(ROWS);

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {CLEAR = 2'd0, DISPLAY = 2'd1, BLANK = 2'd2} stateT;
    localparam stateT       RESET_STATE = CLEAR;
    localparam logic        CLEAR_BUSY_RST = 1'b1;
    localparam logic [15:0] CLEAR_LAST = 16'(COLS * ROWS - 1);
`else
    typedef enum logic [1:0] {DISPLAY = 2'd1, BLANK = 2'd2} stateT;
    localparam stateT       RESET_STATE = BLANK;
    localparam logic        CLEAR_BUSY_RST = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [15:0] glyph;
    } wrEntryT;

    stateT       state;
    wrEntryT     fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   level, levelNext;
    logic        wrReadyReg, overflowReg, badCoordReg, clearBusyReg;
    logic        memWeReg;
    logic [15:0] memAddrReg, memWdataReg;
    logic        brightD1, brightD2, glyphValidReg;
    logic [15:0] glyphReg;
    logic        inClear, pushEn, popEn, headInRange;
    logic [15:0] dispAddr, wrAddr;
    wrEntryT     head;
`ifdef CLEAR_ON_RESET_EN
    logic [15:0] clrCnt;
    assign inClear = (state == CLEAR);
`else
    assign inClear = 1'b0;
`endif

    assign head        = fifoMem[rdPtr];
    assign pushEn      = bus.wr_req && wrReadyReg;
    // Pops follow bright directly so the first visible cycle never issues a write.
    assign popEn       = !inClear && !bus.bright && (level != '0);
    assign headInRange = ({8'd0, head.x} < COLS16) && ({9'd0, head.y} < ROWS16);
    assign dispAddr    = BASE_ADDR + (bus.vCount >> 2) * COLS16 + (bus.hCount >> 2);
    assign wrAddr      = BASE_ADDR + {9'd0, head.y} * COLS16 + {8'd0, head.x};

    always_comb begin
        levelNext = level;
        case ({pushEn, popEn})
            2'b10:   levelNext = level + (AW + 1)'(1);
            2'b01:   levelNext = level - (AW + 1)'(1);
            default: levelNext = level;
        endcase
    end

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (pushEn) fifoMem[wrPtr] <= '{bus.wr_x, bus.wr_y, bus.wr_glyph};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_STATE;
            wrPtr         <= '0;
            rdPtr         <= '0;
            level         <= '0;
            wrReadyReg    <= 1'b0;
            overflowReg   <= 1'b0;
            badCoordReg   <= 1'b0;
            clearBusyReg  <= CLEAR_BUSY_RST;
            memWeReg      <= 1'b0;
            memAddrReg    <= BASE_ADDR;
            memWdataReg   <= '0;
            brightD1      <= 1'b0;
            brightD2      <= 1'b0;
            glyphValidReg <= 1'b0;
            glyphReg      <= '0;
`ifdef CLEAR_ON_RESET_EN
            clrCnt        <= '0;
`endif
        end else begin
            if (pushEn) wrPtr <= wrPtr + AW'(1);
            if (popEn)  rdPtr <= rdPtr + AW'(1);
            level <= levelNext;
            if (bus.wr_req && !wrReadyReg) overflowReg <= 1'b1;

            // Two stages line glyph_valid up with the synchronous memory read.
            brightD1      <= bus.bright && !inClear;
            brightD2      <= brightD1;
            glyphValidReg <= brightD2;
            glyphReg      <= brightD2 ? bus.mem_rdata : 16'd0;

            case (state)
`ifdef CLEAR_ON_RESET_EN
                CLEAR: begin
                    memWeReg    <= 1'b1;
                    memAddrReg  <= BASE_ADDR + clrCnt;
                    memWdataReg <= 16'd0;
                    wrReadyReg  <= 1'b0;
                    if (clrCnt == CLEAR_LAST) begin
                        state        <= bus.bright ? DISPLAY : BLANK;
                        clearBusyReg <= 1'b0;
                        clrCnt       <= '0;
                        wrReadyReg   <= 1'b1;
                    end else begin
                        clrCnt <= clrCnt + 16'd1;
                    end
                end
`endif
                DISPLAY, BLANK: begin
                    state      <= bus.bright ? DISPLAY : BLANK;
                    wrReadyReg <= (levelNext != DEPTH_L);
                    if (bus.bright) begin
                        memAddrReg <= dispAddr;
                        memWeReg   <= 1'b0;
                    end else if (popEn && headInRange) begin
                        memAddrReg  <= wrAddr;
                        memWdataReg <= head.glyph;
                        memWeReg    <= 1'b1;
                    end else begin
                        memWeReg <= 1'b0;
                        if (popEn) badCoordReg <= 1'b1;
                    end
                end
                default: begin
                    state    <= RESET_STATE;
                    memWeReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready    = wrReadyReg;
    assign bus.mem_addr    = memAddrReg;
    assign bus.mem_we      = memWeReg;
    assign bus.mem_wdata   = memWdataReg;
    assign bus.glyph       = glyphReg;
    assign bus.glyph_valid = glyphValidReg;
    assign bus.overflow    = overflowReg;
    assign bus.bad_coord   = badCoordReg;
    assign bus.clear_busy  = clearBusyReg;
endmodule
